// File: rtl/rv32_csr_pkg.sv
// CSR access shared definitions: CSR addresses, write-op encodings, funct3 and state enums.
// Optional access checking is enabled by defining RV32_CSR_ACCESS_CHECK_EN.
package rv32_csr_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned CSR_AW     = 12;
   localparam int unsigned REG_IDX_W  = 5;
   localparam int unsigned FUNCT3_W   = 3;
   localparam int unsigned WRITE_OP_W = 2;

   // Implemented CSRs: user-level counters (all read-only).
   localparam logic [CSR_AW-1:0] CSR_CYCLE    = 12'hC00;
   localparam logic [CSR_AW-1:0] CSR_TIME     = 12'hC01;
   localparam logic [CSR_AW-1:0] CSR_INSTRET  = 12'hC02;
   localparam logic [CSR_AW-1:0] CSR_CYCLEH   = 12'hC80;
   localparam logic [CSR_AW-1:0] CSR_TIMEH    = 12'hC81;
   localparam logic [CSR_AW-1:0] CSR_INSTRETH = 12'hC82;

   localparam logic [WRITE_OP_W-1:0] WRITE_OP_RW = 2'b00;
   localparam logic [WRITE_OP_W-1:0] WRITE_OP_RS = 2'b01;
   localparam logic [WRITE_OP_W-1:0] WRITE_OP_RC = 2'b10;

   typedef enum logic [FUNCT3_W-1:0] {
      F3_NONE0 = 3'b000,
      F3_RW    = 3'b001,
      F3_RS    = 3'b010,
      F3_RC    = 3'b011,
      F3_NONE4 = 3'b100,
      F3_RWI   = 3'b101,
      F3_RSI   = 3'b110,
      F3_RCI   = 3'b111
   } csr_funct3_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } csr_state_e;

   // Decoded view of one CSR instruction.
   typedef struct packed {
      logic                  do_read;
      logic                  do_write;
      logic [WRITE_OP_W-1:0] write_op;
      logic                  use_imm;
      logic                  illegal;
   } csr_dec_t;

   // Request fields held for the duration of one access.
   typedef struct packed {
      logic [CSR_AW-1:0]     csr;
      logic [REG_IDX_W-1:0]  rd;
      logic [XLEN-1:0]       operand;
      logic                  do_read;
      logic                  do_write;
      logic [WRITE_OP_W-1:0] write_op;
      logic                  illegal;
   } csr_req_t;

   // True for addresses backed by the CSR file.
   function automatic logic csr_implemented(input logic [CSR_AW-1:0] addr);
      logic hit;
      case (addr)
         CSR_CYCLE, CSR_TIME, CSR_INSTRET,
         CSR_CYCLEH, CSR_TIMEH, CSR_INSTRETH: hit = 1'b1;
         default:                            hit = 1'b0;
      endcase
      return hit;
   endfunction

   // funct3[1:0]-1 mapping: RW->00, RS->01, RC->10.
   function automatic logic [WRITE_OP_W-1:0] funct3_to_write_op(input logic [FUNCT3_W-1:0] f3);
      logic [WRITE_OP_W-1:0] op;
      case (f3[1:0])
         2'b10:   op = WRITE_OP_RS;
         2'b11:   op = WRITE_OP_RC;
         default: op = WRITE_OP_RW;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32_csr_decode.sv
// Combinational CSR instruction decode: read/write needs, write op, operand source, legality.
// Legality checks are active only when RV32_CSR_ACCESS_CHECK_EN is defined.
module rv32_csr_decode
   import rv32_csr_pkg::*;
(
   input  logic [FUNCT3_W-1:0]  i_funct3,
   input  logic [CSR_AW-1:0]    i_csr,
   input  logic [REG_IDX_W-1:0] i_rs1_field,
   input  logic [REG_IDX_W-1:0] i_rd,
   output csr_dec_t             o_dec
);

   logic w_is_csr;
   logic w_is_rw;
   logic w_read_only;
   logic w_write_req;

   // Classify funct3 and derive the side-effect suppression rules.
   always_comb begin
      w_is_csr    = 1'b0;
      w_is_rw     = 1'b0;
      w_read_only = (i_csr[11:10] == 2'b11);
      o_dec       = '0;

      case (csr_funct3_e'(i_funct3))
         F3_RW, F3_RWI:                 begin w_is_csr = 1'b1; w_is_rw = 1'b1; end
         F3_RS, F3_RC, F3_RSI, F3_RCI:  w_is_csr = 1'b1;
         default:                       w_is_csr = 1'b0;
      endcase

      w_write_req    = w_is_csr && (w_is_rw || (i_rs1_field != '0));
      o_dec.use_imm  = i_funct3[2];
      o_dec.write_op = funct3_to_write_op(i_funct3);
      o_dec.do_read  = w_is_csr && !(w_is_rw && (i_rd == '0));
`ifdef RV32_CSR_ACCESS_CHECK_EN
      o_dec.illegal  = !w_is_csr || !csr_implemented(i_csr) || (w_write_req && w_read_only);
      o_dec.do_write = w_write_req && !o_dec.illegal;
`else
      // Without checking, writes to read-only space are dropped silently.
      o_dec.illegal  = 1'b0;
      o_dec.do_write = w_write_req && !w_read_only;
`endif
   end

endmodule

// File: rtl/rv32_csr_access.sv
// CSR port initiator: sequences each CSR instruction as a read phase then a write phase
// and returns the old CSR value for rd. Access checking via RV32_CSR_ACCESS_CHECK_EN.
module rv32_csr_access
   import rv32_csr_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic [FUNCT3_W-1:0]   funct3_in,
   input  logic [CSR_AW-1:0]     csr_in,
   input  logic [REG_IDX_W-1:0]  rs1_field_in,
   input  logic [XLEN-1:0]       rs1_value_in,
   input  logic [REG_IDX_W-1:0]  rd_in,
   output logic                  csr_read_out,
   output logic                  csr_write_out,
   output logic [WRITE_OP_W-1:0] csr_write_op_out,
   output logic [CSR_AW-1:0]     csr_addr_out,
   output logic [XLEN-1:0]       csr_result_out,
   input  logic [XLEN-1:0]       csr_read_value_in,
   output logic                  resp_valid_out,
   input  logic                  resp_ready_in,
   output logic [REG_IDX_W-1:0]  rd_out,
   output logic                  rd_write_out,
   output logic [XLEN-1:0]       rd_value_out,
   output logic                  illegal_out
);

   csr_state_e      r_state;
   csr_state_e      w_state_nxt;
   csr_req_t        r_req;
   csr_req_t        w_req_nxt;
   csr_dec_t        w_dec;

   logic            r_req_ready;
   logic            r_csr_read;
   logic            r_csr_write;
   logic            r_resp_valid;
   logic            r_rd_write;
   logic            r_illegal;
   logic [XLEN-1:0] r_rd_value;
   logic [XLEN-1:0] r_old_value;

   logic            w_req_ready_nxt;
   logic            w_csr_read_nxt;
   logic            w_csr_write_nxt;
   logic            w_resp_valid_nxt;
   logic            w_rd_write_nxt;
   logic            w_illegal_nxt;
   logic [XLEN-1:0] w_rd_value_nxt;
   logic [XLEN-1:0] w_old_value_nxt;
   logic            w_accept;
   logic            w_rd_write_c;

   rv32_csr_decode u_decode (
      .i_funct3    (funct3_in),
      .i_csr       (csr_in),
      .i_rs1_field (rs1_field_in),
      .i_rd        (rd_in),
      .o_dec       (w_dec)
   );

   // Request handshake and the record latched on acceptance.
   always_comb begin
      w_accept           = (r_state == ST_IDLE) && r_req_ready && req_valid_in;
      w_req_nxt          = '0;
      w_req_nxt.csr      = csr_in;
      w_req_nxt.rd       = rd_in;
      w_req_nxt.operand  = w_dec.use_imm ? XLEN'({rs1_field_in}) : rs1_value_in;
      w_req_nxt.do_read  = w_dec.do_read;
      w_req_nxt.do_write = w_dec.do_write;
      w_req_nxt.write_op = w_dec.write_op;
      w_req_nxt.illegal  = w_dec.illegal;
      w_rd_write_c       = r_req.do_read && !r_req.illegal && (r_req.rd != '0);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      w_state_nxt      = r_state;
      w_req_ready_nxt  = r_req_ready;
      w_csr_read_nxt   = 1'b0;
      w_csr_write_nxt  = 1'b0;
      w_resp_valid_nxt = r_resp_valid;
      w_rd_write_nxt   = r_rd_write;
      w_illegal_nxt    = r_illegal;
      w_rd_value_nxt   = r_rd_value;
      w_old_value_nxt  = r_old_value;

      case (r_state)
         ST_IDLE: begin
            w_req_ready_nxt = 1'b1;
            if (w_accept) begin
               w_state_nxt     = ST_READ;
               w_req_ready_nxt = 1'b0;
               w_csr_read_nxt  = w_dec.do_read;
            end
         end
         ST_READ: begin
            w_old_value_nxt = r_req.do_read ? csr_read_value_in : '0;
            if (r_req.do_write && !r_req.illegal) begin
               w_state_nxt     = ST_WRITE;
               w_csr_write_nxt = 1'b1;
            end else begin
               w_state_nxt      = ST_RESP;
               w_resp_valid_nxt = 1'b1;
               w_rd_write_nxt   = w_rd_write_c;
               w_illegal_nxt    = r_req.illegal;
               w_rd_value_nxt   = w_old_value_nxt;
            end
         end
         ST_WRITE: begin
            w_state_nxt      = ST_RESP;
            w_resp_valid_nxt = 1'b1;
            w_rd_write_nxt   = w_rd_write_c;
            w_illegal_nxt    = r_req.illegal;
            w_rd_value_nxt   = r_old_value;
         end
         ST_RESP: begin
            if (resp_ready_in) begin
               w_state_nxt      = ST_IDLE;
               w_req_ready_nxt  = 1'b1;
               w_resp_valid_nxt = 1'b0;
               w_rd_write_nxt   = 1'b0;
               w_illegal_nxt    = 1'b0;
               w_rd_value_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_req_ready_nxt = 1'b1;
         end
      endcase
   end

   // Output and datapath registers; a reset abandons any request in flight.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_req        <= '0;
         r_req_ready  <= 1'b1;
         r_csr_read   <= 1'b0;
         r_csr_write  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_rd_write   <= 1'b0;
         r_illegal    <= 1'b0;
         r_rd_value   <= '0;
         r_old_value  <= '0;
      end else begin
         if (w_accept) r_req <= w_req_nxt;
         r_req_ready  <= w_req_ready_nxt;
         r_csr_read   <= w_csr_read_nxt;
         r_csr_write  <= w_csr_write_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_rd_write   <= w_rd_write_nxt;
         r_illegal    <= w_illegal_nxt;
         r_rd_value   <= w_rd_value_nxt;
         r_old_value  <= w_old_value_nxt;
      end
   end

   // Strobes are gated by reset_n so nothing fires in a reset cycle.
   assign csr_read_out     = r_csr_read  & reset_n;
   assign csr_write_out    = r_csr_write & reset_n;
   assign csr_write_op_out = r_req.write_op;
   assign csr_addr_out     = r_req.csr;
   assign csr_result_out   = r_req.operand;
   assign req_ready_out    = r_req_ready;
   assign resp_valid_out   = r_resp_valid;
   assign rd_out           = r_req.rd;
   assign rd_write_out     = r_rd_write;
   assign rd_value_out     = r_rd_value;
   assign illegal_out      = r_illegal;

endmodule

// File: tb/tb_rv32_csr_access.sv
// Directed testbench for rv32_csr_access; expectations follow RV32_CSR_ACCESS_CHECK_EN.
module tb_rv32_csr_access;
   import rv32_csr_pkg::*;

`ifdef RV32_CSR_ACCESS_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        req_valid_in;
   logic        req_ready_out;
   logic [2:0]  funct3_in;
   logic [11:0] csr_in;
   logic [4:0]  rs1_field_in;
   logic [31:0] rs1_value_in;
   logic [4:0]  rd_in;
   logic        csr_read_out;
   logic        csr_write_out;
   logic [1:0]  csr_write_op_out;
   logic [11:0] csr_addr_out;
   logic [31:0] csr_result_out;
   logic [31:0] csr_read_value_in;
   logic        resp_valid_out;
   logic        resp_ready_in;
   logic [4:0]  rd_out;
   logic        rd_write_out;
   logic [31:0] rd_value_out;
   logic        illegal_out;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   rv32_csr_access dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .req_valid_in      (req_valid_in),
      .req_ready_out     (req_ready_out),
      .funct3_in         (funct3_in),
      .csr_in            (csr_in),
      .rs1_field_in      (rs1_field_in),
      .rs1_value_in      (rs1_value_in),
      .rd_in             (rd_in),
      .csr_read_out      (csr_read_out),
      .csr_write_out     (csr_write_out),
      .csr_write_op_out  (csr_write_op_out),
      .csr_addr_out      (csr_addr_out),
      .csr_result_out    (csr_result_out),
      .csr_read_value_in (csr_read_value_in),
      .resp_valid_out    (resp_valid_out),
      .resp_ready_in     (resp_ready_in),
      .rd_out            (rd_out),
      .rd_write_out      (rd_write_out),
      .rd_value_out      (rd_value_out),
      .illegal_out       (illegal_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and observe until the response; cycle 1 = first cycle after acceptance.
   task automatic exec(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] rs1f,
                       input logic [31:0] rs1v, input logic [4:0] rd,
                       output int rcyc, output int wcyc, output int pcyc,
                       output logic [1:0] wop, output logic [31:0] wres,
                       output logic [11:0] waddr, output int ovl);
      rcyc = 0; wcyc = 0; pcyc = 0; wop = '0; wres = '0; waddr = '0; ovl = 0;
      funct3_in = f3; csr_in = csr; rs1_field_in = rs1f; rs1_value_in = rs1v; rd_in = rd;
      req_valid_in = 1'b1;
      step();
      req_valid_in = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (csr_read_out && rcyc == 0) rcyc = c;
         if (csr_write_out && wcyc == 0) begin
            wcyc = c; wop = csr_write_op_out; wres = csr_result_out; waddr = csr_addr_out;
         end
         if (csr_read_out && csr_write_out) ovl++;
         if (resp_valid_out) begin
            pcyc = c;
            break;
         end
         step();
      end
   endtask

   task automatic finish_resp();
      resp_ready_in = 1'b1;
      step();
      resp_ready_in = 1'b0;
   endtask

   int          rc, wc, pc, ov;
   logic [1:0]  op;
   logic [31:0] res;
   logic [11:0] wa;

   initial begin
      reset_n = 1'b0; req_valid_in = 1'b0; funct3_in = '0; csr_in = '0; rs1_field_in = '0;
      rs1_value_in = '0; rd_in = '0; csr_read_value_in = '0; resp_ready_in = 1'b0;
      #1;
      step(); step();
      reset_n = 1'b1;
      step();
      check("rst_ready",      32'(req_ready_out), 1);
      check("rst_resp_valid", 32'(resp_valid_out), 0);
      check("rst_strobes",    32'({csr_read_out, csr_write_out}), 0);
      check("rst_rd_write",   32'(rd_write_out), 0);
      check("rst_illegal",    32'(illegal_out), 0);
      check("rst_rd_value",   rd_value_out, 0);
      check("rst_addr",       32'(csr_addr_out), 0);

      // CSRRS rd=5 rs1=0 CYCLE: read-only access
      csr_read_value_in = 32'h0000_1234;
      exec(3'b010, CSR_CYCLE, 5'd0, 32'hFFFF_FFFF, 5'd5, rc, wc, pc, op, res, wa, ov);
      check("t1_read_cyc",  rc, 1);
      check("t1_write_cyc", wc, 0);
      check("t1_resp_cyc",  pc, 2);
      check("t1_rd_value",  rd_value_out, 32'h0000_1234);
      check("t1_rd_write",  32'(rd_write_out), 1);
      check("t1_rd_out",    32'(rd_out), 5);
      check("t1_illegal",   32'(illegal_out), 0);
      finish_resp();
      check("t1_released",  32'(resp_valid_out), 0);
      check("t1_ready",     32'(req_ready_out), 1);

      // CSRRW rd=0 to read-only CYCLE: write is never issued
      exec(3'b001, CSR_CYCLE, 5'd1, 32'hDEAD_BEEF, 5'd0, rc, wc, pc, op, res, wa, ov);
      check("t2_read_cyc",  rc, 0);
      check("t2_write_cyc", wc, 0);
      check("t2_resp_cyc",  pc, 2);
      check("t2_rd_write",  32'(rd_write_out), 0);
      check("t2_illegal",   32'(illegal_out), 32'(CHK));
      check("t2_rd_value",  rd_value_out, 0);
      finish_resp();

      // CSRRW rd=0 to a writable address (unimplemented when checking)
      csr_read_value_in = 32'hAAAA_5555;
      exec(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, 5'd0, rc, wc, pc, op, res, wa, ov);
      check("t2b_read_cyc",  rc, 0);
      check("t2b_write_cyc", wc, CHK ? 0 : 2);
      check("t2b_write_op",  32'(op), 0);
      check("t2b_result",    res, CHK ? 32'h0 : 32'hDEAD_BEEF);
      check("t2b_addr",      32'(wa), CHK ? 32'h0 : 32'h340);
      check("t2b_resp_cyc",  pc, CHK ? 2 : 3);
      check("t2b_illegal",   32'(illegal_out), 32'(CHK));
      check("t2b_rd_write",  32'(rd_write_out), 0);
      finish_resp();

      // CSRRCI rd=3 zimm=0x1F: zero-extended immediate operand, RC op
      csr_read_value_in = 32'h0000_00FF;
      exec(3'b111, 12'h340, 5'h1F, 32'h1234_5678, 5'd3, rc, wc, pc, op, res, wa, ov);
      check("t3_read_cyc",  rc, 1);
      check("t3_write_cyc", wc, CHK ? 0 : 2);
      check("t3_write_op",  32'(op), CHK ? 0 : 2);
      check("t3_result",    res, CHK ? 32'h0 : 32'h0000_001F);
      check("t3_resp_cyc",  pc, CHK ? 2 : 3);
      check("t3_rd_value",  rd_value_out, 32'h0000_00FF);
      check("t3_rd_write",  32'(rd_write_out), 32'(!CHK));
      check("t3_illegal",   32'(illegal_out), 32'(CHK));
      check("t3_overlap",   ov, 0);
      finish_resp();

      // Response held under backpressure; a new request waits
      csr_read_value_in = 32'h0000_0055;
      exec(3'b010, CSR_INSTRET, 5'd0, 32'h0, 5'd9, rc, wc, pc, op, res, wa, ov);
      check("t4_resp_cyc", pc, 2);
      funct3_in = 3'b010; csr_in = CSR_TIME; rs1_field_in = 5'd0; rd_in = 5'd4;
      req_valid_in = 1'b1;
      csr_read_value_in = 32'h0000_0077;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t4_hold_valid", 32'(resp_valid_out), 1);
         check("t4_hold_value", rd_value_out, 32'h0000_0055);
         check("t4_hold_rd",    32'(rd_out), 9);
         check("t4_hold_ready", 32'(req_ready_out), 0);
         check("t4_hold_read",  32'(csr_read_out), 0);
      end
      req_valid_in = 1'b0;
      finish_resp();
      check("t4_ready", 32'(req_ready_out), 1);
      step();
      check("t4_not_taken", 32'({csr_read_out, resp_valid_out}), 0);

      // Reset asserted while in the write phase
      funct3_in = 3'b001; csr_in = 12'h340; rs1_field_in = 5'd2; rs1_value_in = 32'h77; rd_in = 5'd1;
      req_valid_in = 1'b1;
      step();
      req_valid_in = 1'b0;
      step();
      check("t5_write_phase", 32'(csr_write_out), 32'(!CHK));
      reset_n = 1'b0;
      #1;
      check("t5_write_gated", 32'(csr_write_out), 0);
      step();
      check("t5_rst_ready",   32'(req_ready_out), 1);
      check("t5_rst_valid",   32'(resp_valid_out), 0);
      check("t5_rst_strobes", 32'({csr_read_out, csr_write_out}), 0);
      check("t5_rst_rd",      32'(rd_out), 0);
      check("t5_rst_value",   rd_value_out, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t5_no_resp", 32'({resp_valid_out, csr_write_out}), 0);
      end

      // Back-to-back CSRRS with writeback always ready
      begin
         int   acc [3];
         int   rsp [3];
         int   na;
         int   nr;
         int   ovl;
         logic acc_now;
         na = 0; nr = 0; ovl = 0;
         csr_read_value_in = 32'h00C0_FFEE;
         funct3_in = 3'b010; csr_in = CSR_TIME; rs1_field_in = 5'd0; rd_in = 5'd7;
         req_valid_in = 1'b1; resp_ready_in = 1'b1;
         for (int c = 0; c < 40 && nr < 3; c++) begin
            if (csr_read_out && csr_write_out) ovl++;
            if (resp_valid_out) begin
               check("t6_rd_value", rd_value_out, 32'h00C0_FFEE);
               check("t6_rd_out",   32'(rd_out), 32'(7 + nr));
               rsp[nr] = c;
               nr++;
            end
            acc_now = req_valid_in && req_ready_out;
            if (acc_now) acc[na] = c;
            step();
            if (acc_now) begin
               na++;
               if (na == 3) req_valid_in = 1'b0;
               else rd_in = 5'(7 + na);
            end
         end
         resp_ready_in = 1'b0;
         check("t6_n_accept", na, 3);
         check("t6_n_resp",   nr, 3);
         check("t6_overlap",  ovl, 0);
         check("t6_lat0", rsp[0] - acc[0], 2);
         check("t6_gap1", acc[1] - rsp[0], 1);
         check("t6_lat1", rsp[1] - acc[1], 2);
         check("t6_gap2", acc[2] - rsp[1], 1);
         check("t6_lat2", rsp[2] - acc[2], 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
